// File: rtl/axi4_read_arbiter_rr.sv
// axi4_read_arbiter_rr
// Arbitrates the AR channels of NR_OF_MASTERS_P AXI4 masters onto one slave
// port and routes R bursts back to the requester through an in-order
// routing FIFO. It supports round-robin or fixed-priority arbitration and
// has a bounded number of outstanding bursts.

module axi4_read_arbiter_rr #(
  parameter int AXI_ID_WIDTH_P    = -1,
  parameter int AXI_ADDR_WIDTH_P  = -1,
  parameter int AXI_DATA_WIDTH_P  = -1,
  parameter int NR_OF_MASTERS_P   = -1,
  parameter int MAX_OUTSTANDING_P = 4,
  parameter int ARB_MODE_P        = 0
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  // master AR channels
  input  logic [NR_OF_MASTERS_P-1:0][AXI_ID_WIDTH_P-1:0]     mst_arid,
  input  logic [NR_OF_MASTERS_P-1:0][AXI_ADDR_WIDTH_P-1:0]   mst_araddr,
  input  logic [NR_OF_MASTERS_P-1:0][7:0]                    mst_arlen,
  input  logic [NR_OF_MASTERS_P-1:0][2:0]                    mst_arsize,
  input  logic [NR_OF_MASTERS_P-1:0][1:0]                    mst_arburst,
  input  logic [NR_OF_MASTERS_P-1:0][3:0]                    mst_arregion,
  input  logic [NR_OF_MASTERS_P-1:0]                         mst_arvalid,
  output logic [NR_OF_MASTERS_P-1:0]                         mst_arready,
  // master R channels (payload shared, valid/ready per master)
  output logic [AXI_ID_WIDTH_P-1:0]                          mst_rid,
  output logic [1:0]                                         mst_rresp,
  output logic [AXI_DATA_WIDTH_P-1:0]                        mst_rdata,
  output logic                                               mst_rlast,
  output logic [NR_OF_MASTERS_P-1:0]                         mst_rvalid,
  input  logic [NR_OF_MASTERS_P-1:0]                         mst_rready,
  // slave AR channel
  output logic [AXI_ID_WIDTH_P-1:0]                          slv_arid,
  output logic [AXI_ADDR_WIDTH_P-1:0]                        slv_araddr,
  output logic [7:0]                                         slv_arlen,
  output logic [2:0]                                         slv_arsize,
  output logic [1:0]                                         slv_arburst,
  output logic [3:0]                                         slv_arregion,
  output logic                                               slv_arvalid,
  input  logic                                               slv_arready,
  // slave R channel
  input  logic [AXI_ID_WIDTH_P-1:0]                          slv_rid,
  input  logic [1:0]                                         slv_rresp,
  input  logic [AXI_DATA_WIDTH_P-1:0]                        slv_rdata,
  input  logic                                               slv_rlast,
  input  logic                                               slv_rvalid,
  output logic                                               slv_rready,
  // bursts accepted by the slave and not yet completed
  output logic [$clog2(MAX_OUTSTANDING_P+1)-1:0]             rd_outstanding
);

  localparam int IDX_W = $clog2(NR_OF_MASTERS_P);
  localparam int PTR_W = (MAX_OUTSTANDING_P > 1) ? $clog2(MAX_OUTSTANDING_P) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING_P + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING_P);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING_P - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_OF_MASTERS_P - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING_P];

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand_idx;
  logic [IDX_W-1:0] head_idx;
  logic             fifo_nempty;
  logic             push;
  logic             pop;

  // Advance a routing FIFO pointer, wrapping at the (possibly non-power-of-2) depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Pick the next master to grant: fixed priority or round-robin from rr_ptr_q+1.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    if (ARB_MODE_P == 1) begin
      for (int i = NR_OF_MASTERS_P - 1; i >= 0; i--) begin
        if (mst_arvalid[i]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < NR_OF_MASTERS_P; k++) begin
        cand_idx = IDX_W'((int'(rr_ptr_q) + 1 + k) % NR_OF_MASTERS_P);
        if (!win_found && mst_arvalid[cand_idx]) begin
          win_found = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end
  end

  // AR FSM: latch a winner in IDLE, hold it in GRANT until the slave accepts.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        // count_q is registered, so a pop in a full cycle only unblocks the next one
        if (win_found && (count_q < MAX_CNT)) begin
          state_d = GRANT;
          grant_d = win_idx;
        end
      end
      GRANT: begin
        if (slv_arready) begin
          state_d  = IDLE;
          push     = 1'b1;
          rr_ptr_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Routing FIFO control: head selects the R destination, rlast handshake pops.
  always_comb begin
    head_idx    = fifo_q[rd_ptr_q];
    fifo_nempty = (count_q != '0);
    slv_rready  = rst_n & fifo_nempty & mst_rready[head_idx];
    pop         = slv_rvalid & slv_rready & slv_rlast;
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Handshake outputs, forced inactive while reset is asserted.
  always_comb begin
    slv_arvalid = rst_n & (state_q == GRANT);
    mst_arready = '0;
    if (slv_arvalid) mst_arready[grant_q] = slv_arready;
    mst_rvalid  = '0;
    if (rst_n && fifo_nempty) mst_rvalid[head_idx] = slv_rvalid;
  end

  assign slv_arid     = mst_arid[grant_q];
  assign slv_araddr   = mst_araddr[grant_q];
  assign slv_arlen    = mst_arlen[grant_q];
  assign slv_arsize   = mst_arsize[grant_q];
  assign slv_arburst  = mst_arburst[grant_q];
  assign slv_arregion = mst_arregion[grant_q];

  assign mst_rid   = slv_rid;
  assign mst_rresp = slv_rresp;
  assign mst_rdata = slv_rdata;
  assign mst_rlast = slv_rlast;

  assign rd_outstanding = count_q;

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= LAST_IDX;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Routing FIFO storage: write the granted index on each accepted AR.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; count_q gates every
    // read, so stale entries are never used and the array can map to plain RAM.
    if (push) fifo_q[wr_ptr_q] <= grant_q;
  end

endmodule

// File: tb/tb_axi4_read_arbiter_rr.sv
// Directed bench for axi4_read_arbiter_rr. Three instances share the input
// stimulus: A (round-robin, depth 3), B (fixed priority, depth 4) and
// C (round-robin, depth 2). Each scenario resets all three and checks one.

module tb_axi4_read_arbiter_rr;

  localparam int ID_W   = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NR     = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [NR-1:0][ID_W-1:0]   mst_arid;
  logic [NR-1:0][ADDR_W-1:0] mst_araddr;
  logic [NR-1:0][7:0]        mst_arlen;
  logic [NR-1:0][2:0]        mst_arsize;
  logic [NR-1:0][1:0]        mst_arburst;
  logic [NR-1:0][3:0]        mst_arregion;
  logic [NR-1:0]             mst_arvalid;
  logic [NR-1:0]             mst_rready;
  logic                      slv_arready;
  logic [ID_W-1:0]           slv_rid;
  logic [1:0]                slv_rresp;
  logic [DATA_W-1:0]         slv_rdata;
  logic                      slv_rlast;
  logic                      slv_rvalid;

  logic [NR-1:0]     mst_arready  [3];
  logic [ID_W-1:0]   mst_rid      [3];
  logic [1:0]        mst_rresp    [3];
  logic [DATA_W-1:0] mst_rdata    [3];
  logic              mst_rlast    [3];
  logic [NR-1:0]     mst_rvalid   [3];
  logic [ID_W-1:0]   slv_arid     [3];
  logic [ADDR_W-1:0] slv_araddr   [3];
  logic [7:0]        slv_arlen    [3];
  logic [2:0]        slv_arsize   [3];
  logic [1:0]        slv_arburst  [3];
  logic [3:0]        slv_arregion [3];
  logic              slv_arvalid  [3];
  logic              slv_rready   [3];
  logic [1:0]        out_a;
  logic [2:0]        out_b;
  logic [1:0]        out_c;

  axi4_read_arbiter_rr #(
    .AXI_ID_WIDTH_P(ID_W), .AXI_ADDR_WIDTH_P(ADDR_W), .AXI_DATA_WIDTH_P(DATA_W),
    .NR_OF_MASTERS_P(NR), .MAX_OUTSTANDING_P(3), .ARB_MODE_P(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .mst_arid(mst_arid), .mst_araddr(mst_araddr), .mst_arlen(mst_arlen),
    .mst_arsize(mst_arsize), .mst_arburst(mst_arburst), .mst_arregion(mst_arregion),
    .mst_arvalid(mst_arvalid), .mst_arready(mst_arready[0]),
    .mst_rid(mst_rid[0]), .mst_rresp(mst_rresp[0]), .mst_rdata(mst_rdata[0]),
    .mst_rlast(mst_rlast[0]), .mst_rvalid(mst_rvalid[0]), .mst_rready(mst_rready),
    .slv_arid(slv_arid[0]), .slv_araddr(slv_araddr[0]), .slv_arlen(slv_arlen[0]),
    .slv_arsize(slv_arsize[0]), .slv_arburst(slv_arburst[0]), .slv_arregion(slv_arregion[0]),
    .slv_arvalid(slv_arvalid[0]), .slv_arready(slv_arready),
    .slv_rid(slv_rid), .slv_rresp(slv_rresp), .slv_rdata(slv_rdata),
    .slv_rlast(slv_rlast), .slv_rvalid(slv_rvalid), .slv_rready(slv_rready[0]),
    .rd_outstanding(out_a)
  );

  axi4_read_arbiter_rr #(
    .AXI_ID_WIDTH_P(ID_W), .AXI_ADDR_WIDTH_P(ADDR_W), .AXI_DATA_WIDTH_P(DATA_W),
    .NR_OF_MASTERS_P(NR), .MAX_OUTSTANDING_P(4), .ARB_MODE_P(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .mst_arid(mst_arid), .mst_araddr(mst_araddr), .mst_arlen(mst_arlen),
    .mst_arsize(mst_arsize), .mst_arburst(mst_arburst), .mst_arregion(mst_arregion),
    .mst_arvalid(mst_arvalid), .mst_arready(mst_arready[1]),
    .mst_rid(mst_rid[1]), .mst_rresp(mst_rresp[1]), .mst_rdata(mst_rdata[1]),
    .mst_rlast(mst_rlast[1]), .mst_rvalid(mst_rvalid[1]), .mst_rready(mst_rready),
    .slv_arid(slv_arid[1]), .slv_araddr(slv_araddr[1]), .slv_arlen(slv_arlen[1]),
    .slv_arsize(slv_arsize[1]), .slv_arburst(slv_arburst[1]), .slv_arregion(slv_arregion[1]),
    .slv_arvalid(slv_arvalid[1]), .slv_arready(slv_arready),
    .slv_rid(slv_rid), .slv_rresp(slv_rresp), .slv_rdata(slv_rdata),
    .slv_rlast(slv_rlast), .slv_rvalid(slv_rvalid), .slv_rready(slv_rready[1]),
    .rd_outstanding(out_b)
  );

  axi4_read_arbiter_rr #(
    .AXI_ID_WIDTH_P(ID_W), .AXI_ADDR_WIDTH_P(ADDR_W), .AXI_DATA_WIDTH_P(DATA_W),
    .NR_OF_MASTERS_P(NR), .MAX_OUTSTANDING_P(2), .ARB_MODE_P(0)
  ) u_c (
    .clk(clk), .rst_n(rst_n),
    .mst_arid(mst_arid), .mst_araddr(mst_araddr), .mst_arlen(mst_arlen),
    .mst_arsize(mst_arsize), .mst_arburst(mst_arburst), .mst_arregion(mst_arregion),
    .mst_arvalid(mst_arvalid), .mst_arready(mst_arready[2]),
    .mst_rid(mst_rid[2]), .mst_rresp(mst_rresp[2]), .mst_rdata(mst_rdata[2]),
    .mst_rlast(mst_rlast[2]), .mst_rvalid(mst_rvalid[2]), .mst_rready(mst_rready),
    .slv_arid(slv_arid[2]), .slv_araddr(slv_araddr[2]), .slv_arlen(slv_arlen[2]),
    .slv_arsize(slv_arsize[2]), .slv_arburst(slv_arburst[2]), .slv_arregion(slv_arregion[2]),
    .slv_arvalid(slv_arvalid[2]), .slv_arready(slv_arready),
    .slv_rid(slv_rid), .slv_rresp(slv_rresp), .slv_rdata(slv_rdata),
    .slv_rlast(slv_rlast), .slv_rvalid(slv_rvalid), .slv_rready(slv_rready[2]),
    .rd_outstanding(out_c)
  );

  // One cycle of table stimulus for instance A with its expected outputs.
  typedef struct {
    logic [2:0] arvalid;
    logic       arready;
    logic       rvalid;
    logic       rlast;
    logic [2:0] rready;
    logic       exp_arvalid;
    logic [7:0] exp_arid;
    logic [2:0] exp_mst_arready;
    logic [2:0] exp_mst_rvalid;
    logic       exp_rready;
    logic [1:0] exp_out;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mkv(logic [2:0] av, logic ar, logic rv, logic rl, logic [2:0] rr,
                               logic e_av, logic [7:0] e_id, logic [2:0] e_mar,
                               logic [2:0] e_mrv, logic e_rr, logic [1:0] e_out);
    vec_t v;
    v.arvalid = av; v.arready = ar; v.rvalid = rv; v.rlast = rl; v.rready = rr;
    v.exp_arvalid = e_av; v.exp_arid = e_id; v.exp_mst_arready = e_mar;
    v.exp_mst_rvalid = e_mrv; v.exp_rready = e_rr; v.exp_out = e_out;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    mst_arvalid = '0;
    mst_rready  = 3'b111;
    slv_arready = 1'b1;
    slv_rvalid  = 1'b0;
    slv_rlast   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  vec_t vt [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      mst_arid[i]     = ID_W'(8'h10 + i);
      mst_araddr[i]   = ADDR_W'(32'h1000 * (i + 1));
      mst_arlen[i]    = 8'd3;
      mst_arsize[i]   = 3'd2;
      mst_arburst[i]  = 2'd1;
      mst_arregion[i] = 4'd0;
    end
    slv_rid   = 8'h55;
    slv_rresp = 2'b00;
    slv_rdata = '0;

    //          arv     ar   rv   rl   rrdy  | e_av e_id   e_mar   e_mrv   e_rr e_out
    vt[0]  = mkv(3'b111, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 2'd0);
    vt[1]  = mkv(3'b111, 1'b1, 1'b0, 1'b0, 3'b111, 1'b1, 8'h10, 3'b001, 3'b000, 1'b0, 2'd0);
    vt[2]  = mkv(3'b111, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 2'd1);
    vt[3]  = mkv(3'b111, 1'b1, 1'b1, 1'b1, 3'b111, 1'b1, 8'h11, 3'b010, 3'b001, 1'b1, 2'd1);
    vt[4]  = mkv(3'b111, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 2'd1);
    vt[5]  = mkv(3'b111, 1'b1, 1'b0, 1'b0, 3'b111, 1'b1, 8'h12, 3'b100, 3'b000, 1'b1, 2'd1);
    vt[6]  = mkv(3'b111, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 2'd2);
    vt[7]  = mkv(3'b111, 1'b1, 1'b0, 1'b0, 3'b111, 1'b1, 8'h10, 3'b001, 3'b000, 1'b1, 2'd2);
    vt[8]  = mkv(3'b111, 1'b1, 1'b1, 1'b0, 3'b101, 1'b0, 8'h00, 3'b000, 3'b010, 1'b0, 2'd3);
    vt[9]  = mkv(3'b111, 1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 8'h00, 3'b000, 3'b010, 1'b1, 2'd3);
    vt[10] = mkv(3'b111, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 2'd2);
    vt[11] = mkv(3'b111, 1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 8'h11, 3'b000, 3'b000, 1'b1, 2'd2);
    vt[12] = mkv(3'b111, 1'b1, 1'b0, 1'b0, 3'b111, 1'b1, 8'h11, 3'b010, 3'b000, 1'b1, 2'd2);
    vt[13] = mkv(3'b111, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 2'd3);

    // ---- table: RR order 0,1,2,0, overlap of push/pop, full at depth 3, stall
    do_reset();
    for (int i = 0; i < 14; i++) begin
      mst_arvalid = vt[i].arvalid;
      slv_arready = vt[i].arready;
      slv_rvalid  = vt[i].rvalid;
      slv_rlast   = vt[i].rlast;
      mst_rready  = vt[i].rready;
      #1;
      check($sformatf("row%0d slv_arvalid", i), slv_arvalid[0], vt[i].exp_arvalid);
      if (vt[i].exp_arvalid)
        check($sformatf("row%0d slv_arid", i), slv_arid[0], vt[i].exp_arid);
      check($sformatf("row%0d mst_arready", i), mst_arready[0], vt[i].exp_mst_arready);
      check($sformatf("row%0d mst_rvalid", i), mst_rvalid[0], vt[i].exp_mst_rvalid);
      check($sformatf("row%0d slv_rready", i), slv_rready[0], vt[i].exp_rready);
      check($sformatf("row%0d rd_outstanding", i), out_a, vt[i].exp_out);
      tick();
    end

    // ---- fixed priority: master 1 beats master 2 until it drops arvalid
    do_reset();
    mst_arvalid = 3'b110;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("fix idle arvalid", slv_arvalid[1], 1'b0);
      tick();
      #1;
      check("fix grant arid", slv_arid[1], 8'h11);
      check("fix grant arready", mst_arready[1], 3'b010);
      tick();
    end
    mst_arvalid = 3'b100;
    #1;
    check("fix outstanding 3", out_b, 3'd3);
    tick();
    #1;
    check("fix m2 arid", slv_arid[1], 8'h12);
    check("fix m2 arready", mst_arready[1], 3'b100);
    tick();
    #1;
    check("fix outstanding 4", out_b, 3'd4);

    // ---- depth 2: third AR blocked until one rlast, then granted 2 cycles later
    do_reset();
    mst_arvalid = 3'b111;
    for (int k = 0; k < 4; k++) tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("full no arvalid", slv_arvalid[2], 1'b0);
      check("full outstanding", out_c, 2'd2);
      tick();
    end
    slv_rvalid = 1'b1;
    slv_rlast  = 1'b1;
    #1;
    check("full pop rready", slv_rready[2], 1'b1);
    tick();
    slv_rvalid = 1'b0;
    slv_rlast  = 1'b0;
    #1;
    check("full +1 arvalid", slv_arvalid[2], 1'b0);
    check("full +1 outstanding", out_c, 2'd1);
    tick();
    #1;
    check("full +2 arvalid", slv_arvalid[2], 1'b1);
    check("full +2 arid", slv_arid[2], 8'h12);
    tick();

    // ---- R routing: 4 beats to master 2 (with a stall), then 4 to master 0
    do_reset();
    mst_arvalid = 3'b100;
    tick();
    tick();
    mst_arvalid = 3'b001;
    tick();
    tick();
    mst_arvalid = 3'b000;
    #1;
    check("rt outstanding 2", out_a, 2'd2);
    for (int m = 0; m < 2; m++) begin
      for (int b = 0; b < 4; b++) begin
        slv_rvalid = 1'b1;
        slv_rlast  = (b == 3);
        slv_rdata  = DATA_W'(32'hA000_0000 + m * 16 + b);
        if (m == 0 && b == 1) begin
          mst_rready = 3'b011;
          #1;
          check("rt stall rvalid", mst_rvalid[0], 3'b100);
          check("rt stall rready", slv_rready[0], 1'b0);
          tick();
          mst_rready = 3'b111;
        end
        #1;
        check($sformatf("rt m%0d b%0d rvalid", m, b), mst_rvalid[0], (m == 0) ? 3'b100 : 3'b001);
        check($sformatf("rt m%0d b%0d rready", m, b), slv_rready[0], 1'b1);
        check($sformatf("rt m%0d b%0d rdata", m, b), mst_rdata[0], 32'hA000_0000 + m * 16 + b);
        tick();
      end
    end
    slv_rlast = 1'b0;
    #1;
    check("rt empty rvalid", mst_rvalid[0], 3'b000);
    check("rt empty rready", slv_rready[0], 1'b0);
    check("rt empty outstanding", out_a, 2'd0);
    slv_rvalid = 1'b0;

    // ---- slave holds arready low for 5 cycles: grant and fields stay put
    do_reset();
    mst_arvalid = 3'b111;
    slv_arready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      mst_arvalid = (k % 2 == 0) ? 3'b001 : 3'b111;
      #1;
      check("hold arvalid", slv_arvalid[0], 1'b1);
      check("hold arid", slv_arid[0], 8'h10);
      check("hold araddr", slv_araddr[0], 32'h1000);
      check("hold arready", mst_arready[0], 3'b000);
      tick();
    end
    slv_arready = 1'b1;
    #1;
    check("hold release arready", mst_arready[0], 3'b001);
    tick();
    #1;
    check("hold after arvalid", slv_arvalid[0], 1'b0);
    check("hold after outstanding", out_a, 2'd1);

    // ---- reset with 2 bursts outstanding while a grant is held
    do_reset();
    mst_arvalid = 3'b111;
    for (int k = 0; k < 4; k++) tick();
    #1;
    check("rst pre outstanding", out_a, 2'd2);
    tick();
    rst_n      = 1'b0;
    slv_rvalid = 1'b1;
    slv_rlast  = 1'b1;
    #1;
    check("rst in arvalid", slv_arvalid[0], 1'b0);
    check("rst in arready", mst_arready[0], 3'b000);
    check("rst in rvalid", mst_rvalid[0], 3'b000);
    check("rst in rready", slv_rready[0], 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst out outstanding", out_a, 2'd0);
    check("rst out arvalid", slv_arvalid[0], 1'b0);
    check("rst out rvalid", mst_rvalid[0], 3'b000);
    check("rst out rready", slv_rready[0], 1'b0);
    tick();
    slv_rvalid = 1'b0;
    slv_rlast  = 1'b0;
    #1;
    check("rst next arvalid", slv_arvalid[0], 1'b1);
    check("rst next arid", slv_arid[0], 8'h10);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
